// File: rtl/refill_memory_if.sv
// Miss-path bus between the instruction-cache controller and the refill memory,
// including the word-wide load port used for preloading or patching contents.
interface refill_memory_if #(
  parameter int ADDR_W = 8
);
  logic                mem_req_i;
  logic [ADDR_W-1:0]   mem_addr_i;
  logic [127:0]        mem_data_o;
  logic                mem_comp_o;
  logic                busy_o;
  logic                ld_en_i;
  logic [ADDR_W+1:0]   ld_addr_i;
  logic [31:0]         ld_data_i;

  modport master (
    output mem_req_i, mem_addr_i, ld_en_i, ld_addr_i, ld_data_i,
    input  mem_data_o, mem_comp_o, busy_o
  );

  modport slave (
    input  mem_req_i, mem_addr_i, ld_en_i, ld_addr_i, ld_data_i,
    output mem_data_o, mem_comp_o, busy_o
  );
endinterface

// File: rtl/refill_memory.sv
// Backing store and line-fill engine: after LATENCY wait cycles it reads four
// words of the requested line, one per cycle, and returns them as a 128-bit line.
module refill_memory #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  refill_memory_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, WAIT, FETCH, DONE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          wait_q, wait_d;
  logic [1:0]          beat_q, beat_d;
  logic [3:0][31:0]    shadow_q, shadow_d;
  logic [127:0]        data_q, data_d;
  logic [31:0]         rd_word;

  logic [31:0] mem_q [0:(4 << ADDR_W)-1];

  // Asynchronous read sees the pre-edge contents, so a same-cycle load-port
  // write to the word being fetched returns the old value.
  assign rd_word = mem_q[{addr_q, beat_q}];

  always_ff @(posedge clk) begin
    if (bus.ld_en_i) mem_q[bus.ld_addr_i] <= bus.ld_data_i;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wait_d   = wait_q;
    beat_d   = beat_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req_i) begin
          addr_d  = bus.mem_addr_i;
          wait_d  = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          beat_d  = '0;
          state_d = FETCH;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      FETCH: begin
        shadow_d[beat_q] = rd_word;
        beat_d           = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          // Last beat bypasses the shadow so the line is complete on DONE entry.
          data_d  = {rd_word, shadow_q[2], shadow_q[1], shadow_q[0]};
          state_d = DONE;
        end
      end
      DONE:    state_d = bus.mem_req_i ? DRAIN : IDLE;
      DRAIN:   if (!bus.mem_req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wait_q   <= '0;
      beat_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wait_q   <= wait_d;
      beat_q   <= beat_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
    end
  end

  assign bus.mem_data_o = data_q;
  assign bus.mem_comp_o = (state_q == DONE);
  assign bus.busy_o     = (state_q != IDLE);

endmodule
